// File: rtl/btb_update_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : btb_update_ctrl                                              |
// | Description : Write-side controller for an 8-set x 2-way BTB. Queues       |
// |               resolved branches, reads the target set, merges the record   |
// |               (hit update / victim allocation) and issues one write.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module btb_update_ctrl #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [31:0]       res_pc,
  input  logic [31:0]       res_target,
  input  logic              res_taken,
  output logic [2:0]        update_index,
  input  logic [127:0]      update_set,
  output logic              write_en,
  output logic [2:0]        write_index,
  output logic [127:0]      write_set,
  output logic              busy,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int REC_W = 65;   // {taken, target, pc}

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Resolution queue
  logic [REC_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic             fifo_full, fifo_empty, push, pop;
  logic [REC_W-1:0] head;

  // Operation being processed
  logic [31:0]      op_pc, op_tgt;
  logic             op_taken;
  logic [127:0]     set_q;
  logic [CNT_W-1:0] cnt_q;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign push       = res_valid && !fifo_full;
  assign pop        = (state_q == ST_IDLE) && !fifo_empty;
  assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];

  // Queue storage: payload only, pointers carry the valid state
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= {res_taken, res_target, res_pc};
  end

  // Queue pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state: one record every three cycles, no hazard on the same set
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_READ;
      ST_READ:  state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Op register loaded from the queue head; set captured at the end of READ
  always_ff @(posedge clk) begin
    if (reset) begin
      op_pc    <= '0;
      op_tgt   <= '0;
      op_taken <= 1'b0;
      set_q    <= '0;
    end else begin
      if (pop) begin
        op_pc    <= head[31:0];
        op_tgt   <= head[63:32];
        op_taken <= head[64];
      end
      if (state_q == ST_READ) set_q <= update_set;
    end
  end

  // Merge of the op into the registered set
  logic [63:0] w0, w1, old_way, new_way, m_w0, m_w1;
  logic [26:0] op_tag;
  logic        hit0, hit1, hit, victim, sel, do_write;
  logic [1:0]  old_ctr, new_ctr;
  logic [31:0] new_tgt;
  logic [127:0] merged;

  // Hit detection (way0 wins on double hit), victim choice and field update
  always_comb begin
    w0      = set_q[63:0];
    w1      = set_q[127:64];
    op_tag  = op_pc[31:5];
    hit0    = w0[63] && (w0[62:36] == op_tag);
    hit1    = w1[63] && (w1[62:36] == op_tag) && !hit0;
    hit     = hit0 || hit1;
    victim  = !w0[63] ? 1'b0 : (!w1[63] ? 1'b1 : set_q[0]);
    sel     = hit ? hit1 : victim;
    old_way = sel ? w1 : w0;
    old_ctr = old_way[3:2];
    new_ctr = 2'b10;
    if (hit) begin
      if (op_taken) new_ctr = (old_ctr == 2'b11) ? 2'b11 : old_ctr + 2'd1;
      else          new_ctr = (old_ctr == 2'b00) ? 2'b00 : old_ctr - 2'd1;
    end
    new_tgt  = op_taken ? op_tgt : old_way[35:4];
    new_way  = {1'b1, op_tag, new_tgt, new_ctr, 2'b00};
    m_w0     = sel ? {w0[63:2], 2'b00} : new_way;
    m_w1     = sel ? new_way : {w1[63:2], 2'b00};
    merged   = {m_w1, m_w0[63:1], ~sel};
    do_write = hit || op_taken;
  end

  // Outputs are forced to reset values while reset is high, even mid-op
  always_comb begin
    res_ready    = reset || !fifo_full;
    busy         = !reset && ((state_q != ST_IDLE) || !fifo_empty);
    update_index = (!reset && state_q == ST_READ) ? op_pc[4:2] : 3'd0;
    write_en     = !reset && (state_q == ST_WRITE) && do_write;
    write_index  = write_en ? op_pc[4:2] : 3'd0;
    write_set    = write_en ? merged : 128'd0;
    wr_count     = reset ? '0 : cnt_q;
  end

  // Saturating count of issued writes
  always_ff @(posedge clk) begin
    if (reset)                       cnt_q <= '0;
    else if (write_en && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end

endmodule
`default_nettype wire

// File: tb/tb_btb_update_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_btb_update_ctrl                                           |
// | Description : Self-checking bench for btb_update_ctrl with storage model,  |
// |               vector table and write scoreboard.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_btb_update_ctrl;

  logic         clk = 1'b0;
  logic         reset, res_valid, res_taken, res_ready;
  logic [31:0]  res_pc, res_target;
  logic [2:0]   update_index, write_index;
  logic [127:0] update_set, write_set;
  logic         write_en, busy;
  logic [15:0]  wr_count;

  always #5 clk = ~clk;

  btb_update_ctrl #(.FIFO_DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_pc(res_pc), .res_target(res_target), .res_taken(res_taken),
    .update_index(update_index), .update_set(update_set),
    .write_en(write_en), .write_index(write_index), .write_set(write_set),
    .busy(busy), .wr_count(wr_count)
  );

  // Storage array owned by one process; preload and clear go through it
  logic [127:0] store [8];
  logic         clr, pl_en;
  logic [2:0]   pl_idx;
  logic [127:0] pl_val;
  assign update_set = store[update_index];

  always @(posedge clk) begin
    if (clr) for (int i = 0; i < 8; i++) store[i] <= '0;
    else if (pl_en) store[pl_idx] <= pl_val;
    else if (write_en) store[write_index] <= write_set;
  end

  int checks = 0, failures = 0, exp_wr = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard of expected writes
  typedef struct packed { logic [2:0] idx; logic [127:0] set; } wr_t;
  wr_t sbq[$];
  int  wcyc[$];
  logic [127:0] mdl [8];

  always @(negedge clk) begin
    wr_t e;
    if (write_en) begin
      checks++;
      wcyc.push_back(cyc);
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual idx=%0d set=%h required none", write_index, write_set);
      end else begin
        e = sbq.pop_front();
        if (write_index !== e.idx || write_set !== e.set) begin
          failures++;
          $display("FAIL sb_write actual idx=%0d set=%h required idx=%0d set=%h",
                   write_index, write_set, e.idx, e.set);
        end
      end
    end
  end

  logic ready_low_seen = 1'b0;
  always @(negedge clk) if (res_valid && !res_ready && !reset) ready_low_seen <= 1'b1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference merge, written field-by-field
  function automatic void merge(input logic [127:0] s, input logic [31:0] pc, input logic [31:0] tgt,
                                input logic tk, output logic we, output logic [127:0] ns);
    logic        v [2];
    logic [26:0] tg [2];
    logic [31:0] ta [2];
    logic [1:0]  c [2];
    int hw, w;
    for (int k = 0; k < 2; k++) begin
      v[k] = s[64*k+63]; tg[k] = s[64*k+36 +: 27]; ta[k] = s[64*k+4 +: 32]; c[k] = s[64*k+2 +: 2];
    end
    hw = -1;
    for (int k = 1; k >= 0; k--) if (v[k] && tg[k] == pc[31:5]) hw = k;
    we = 1'b1;
    w  = 0;
    if (hw >= 0) begin
      w = hw;
      if (tk) begin
        if (c[w] != 2'd3) c[w] = c[w] + 2'd1;
        ta[w] = tgt;
      end else if (c[w] != 2'd0) c[w] = c[w] - 2'd1;
    end else if (tk) begin
      w = !v[0] ? 0 : (!v[1] ? 1 : int'(s[0]));
      v[w] = 1'b1; tg[w] = pc[31:5]; ta[w] = tgt; c[w] = 2'b10;
    end else we = 1'b0;
    ns = '0;
    for (int k = 0; k < 2; k++) begin
      ns[64*k+63] = v[k]; ns[64*k+36 +: 27] = tg[k]; ns[64*k+4 +: 32] = ta[k]; ns[64*k+2 +: 2] = c[k];
    end
    ns[0] = (w == 0);
    if (!we) ns = s;
  endfunction

  task automatic model_push(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    logic we;
    logic [127:0] ns;
    merge(mdl[pc[4:2]], pc, tgt, tk, we, ns);
    mdl[pc[4:2]] = ns;
    if (we) begin
      sbq.push_back({pc[4:2], ns});
      exp_wr++;
    end
  endtask

  // Present a record and return once it is taken at a rising edge (valid left high)
  task automatic accept_one(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                            input bit track, output bit ok);
    int n;
    #1;
    res_pc = pc; res_target = tgt; res_taken = tk; res_valid = 1'b1;
    n = 0;
    while (!res_ready && n < 30) begin @(negedge clk); n++; end
    ok = res_ready;
    if (!ok) return;
    @(posedge clk);
    if (track) model_push(pc, tgt, tk);
  endtask

  typedef struct {
    logic [31:0] pc, tgt; logic tk; logic we; int way; logic [1:0] ctr;
    logic [31:0] etgt; logic lru; logic chk_o; logic [63:0] other;
  } vec_t;
  vec_t tbl [11];

  localparam logic [63:0] W0P = {1'b1, 27'h11, 32'hAAAA_0000, 2'b01, 2'b00};
  localparam logic [63:0] W1P = {1'b1, 27'h22, 32'hBBBB_0000, 2'b11, 2'b00};
  localparam logic [63:0] W0N = {1'b1, 27'h33, 32'h0000_5000, 2'b10, 2'b00};

  initial begin
    bit ok, seen;
    int lat, n, o, wstart;
    logic [127:0] s;

    reset = 1'b1; clr = 1'b1; pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    res_valid = 1'b0; res_pc = '0; res_target = '0; res_taken = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = '0;

    tbl[0]  = '{32'h100C, 32'h2000, 1'b1, 1'b1, 0, 2'd2, 32'h2000, 1'b1, 1'b0, 64'h0};
    tbl[1]  = '{32'h100C, 32'h2000, 1'b1, 1'b1, 0, 2'd3, 32'h2000, 1'b1, 1'b0, 64'h0};
    tbl[2]  = '{32'h100C, 32'h3000, 1'b1, 1'b1, 0, 2'd3, 32'h3000, 1'b1, 1'b0, 64'h0};
    tbl[3]  = '{32'h100C, 32'h4444, 1'b0, 1'b1, 0, 2'd2, 32'h3000, 1'b1, 1'b0, 64'h0};
    tbl[4]  = '{32'h100C, 32'h4444, 1'b0, 1'b1, 0, 2'd1, 32'h3000, 1'b1, 1'b0, 64'h0};
    tbl[5]  = '{32'h100C, 32'h4444, 1'b0, 1'b1, 0, 2'd0, 32'h3000, 1'b1, 1'b0, 64'h0};
    tbl[6]  = '{32'h100C, 32'h4444, 1'b0, 1'b1, 0, 2'd0, 32'h3000, 1'b1, 1'b0, 64'h0};
    tbl[7]  = '{32'h0674, 32'h5000, 1'b1, 1'b1, 0, 2'd2, 32'h5000, 1'b1, 1'b1, W1P};
    tbl[8]  = '{32'h0894, 32'h6000, 1'b1, 1'b1, 1, 2'd2, 32'h6000, 1'b0, 1'b1, W0N};
    tbl[9]  = '{32'h0894, 32'h7777, 1'b0, 1'b1, 1, 2'd1, 32'h6000, 1'b0, 1'b0, 64'h0};
    tbl[10] = '{32'h0044, 32'h9999, 1'b0, 1'b0, 0, 2'd0, 32'h0,    1'b0, 1'b0, 64'h0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_res_ready", 128'(res_ready), 128'(1));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_write_en", 128'(write_en), 128'(0));
    chk("rst_wr_count", 128'(wr_count), 128'(0));
    chk("rst_update_index", 128'(update_index), 128'(0));
    clr = 1'b0; reset = 1'b0;
    pl_en = 1'b1; pl_idx = 3'd5; pl_val = {W1P, W0P}; mdl[5] = {W1P, W0P};
    @(negedge clk);
    pl_en = 1'b0;

    // Single records from an idle, empty controller
    for (int i = 0; i < 11; i++) begin
      accept_one(tbl[i].pc, tbl[i].tgt, tbl[i].tk, 1'b1, ok);
      chk($sformatf("accept_%0d", i), 128'(ok), 128'(1));
      #1 res_valid = 1'b0;
      lat = 0; seen = 1'b0;
      for (int k = 0; k < 4 && !seen; k++) begin
        @(negedge clk); lat++;
        if (write_en) seen = 1'b1;
      end
      n = 0;
      while (busy && n < 10) begin @(negedge clk); n++; end
      chk($sformatf("busy_drop_%0d", i), 128'(busy), 128'(0));
      chk($sformatf("write_seen_%0d", i), 128'(seen), 128'(tbl[i].we));
      chk($sformatf("wr_count_%0d", i), 128'(wr_count), 128'(exp_wr));
      if (tbl[i].we) begin
        chk($sformatf("latency_%0d", i), 128'(lat), 128'(3));
        s = store[tbl[i].pc[4:2]];
        o = 64 * tbl[i].way;
        chk($sformatf("valid_%0d", i), 128'(s[o+63]), 128'(1));
        chk($sformatf("tag_%0d", i), 128'(s[o+36 +: 27]), 128'(tbl[i].pc[31:5]));
        chk($sformatf("ctr_%0d", i), 128'(s[o+2 +: 2]), 128'(tbl[i].ctr));
        chk($sformatf("target_%0d", i), 128'(s[o+4 +: 32]), 128'(tbl[i].etgt));
        chk($sformatf("lru_%0d", i), 128'(s[0]), 128'(tbl[i].lru));
        if (tbl[i].chk_o) begin
          o = 64 * (1 - tbl[i].way);
          chk($sformatf("other_way_%0d", i), 128'(s[o+2 +: 62]), 128'(tbl[i].other[63:2]));
        end
      end
    end

    // Back-to-back burst into a two-entry queue
    wstart = wcyc.size();
    for (int k = 0; k < 4; k++) begin
      accept_one(32'h18 + 32'(k[0]) * 32'h4 + 32'(k[1]) * 32'h20, 32'hC000 + 32'(k), 1'b1, 1'b1, ok);
      chk($sformatf("burst_accept_%0d", k), 128'(ok), 128'(1));
    end
    #1 res_valid = 1'b0;
    n = 0;
    while (busy && n < 40) begin @(negedge clk); n++; end
    chk("burst_busy_drop", 128'(busy), 128'(0));
    chk("burst_ready_low", 128'(ready_low_seen), 128'(1));
    chk("burst_sb_empty", 128'(sbq.size()), 128'(0));
    chk("burst_wr_count", 128'(wr_count), 128'(exp_wr));
    chk("burst_nwrites", 128'(wcyc.size() - wstart), 128'(4));
    for (int k = wstart + 1; k < wcyc.size(); k++)
      chk($sformatf("burst_spacing_%0d", k - wstart), 128'(wcyc[k] - wcyc[k-1]), 128'(3));

    // Reset landing on the WRITE cycle of an op with another queued behind it
    @(negedge clk);
    accept_one(32'h0000_00A0, 32'hDEAD_0000, 1'b1, 1'b0, ok);
    chk("rst6_accept_a", 128'(ok), 128'(1));
    accept_one(32'h0000_00E0, 32'hBEEF_0000, 1'b1, 1'b0, ok);
    chk("rst6_accept_b", 128'(ok), 128'(1));
    @(posedge clk);
    #1 reset = 1'b1; res_valid = 1'b0;
    @(negedge clk);
    chk("rst6_write_en", 128'(write_en), 128'(0));
    chk("rst6_write_index", 128'(write_index), 128'(0));
    chk("rst6_write_set", write_set, 128'(0));
    chk("rst6_busy", 128'(busy), 128'(0));
    chk("rst6_res_ready", 128'(res_ready), 128'(1));
    chk("rst6_wr_count", 128'(wr_count), 128'(0));
    chk("rst6_update_index", 128'(update_index), 128'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    exp_wr = 0;
    repeat (8) @(negedge clk);
    chk("rst6_busy_after", 128'(busy), 128'(0));
    chk("rst6_wr_count_after", 128'(wr_count), 128'(0));
    chk("rst6_sb_empty", 128'(sbq.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
